// File: rtl/fetch_queue.sv
// Fetch PC + instruction FIFO; head visible one cycle after fetch, decode stalls via deq_ready.
// Branch flushes and redirects with priority; optional FETCH_HALT_EN stops fetch after a 32'hFFFF_FFFF word.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_addr,
  output logic                     imem_rd,
  input  logic [31:0]              imem_data,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_target,
  input  logic                     deq_ready,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_HALT_EN
  ,
  output logic                     halted
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   fetch_pc;
  logic          enq;
  logic          deq;
  logic          halt_q;

  assign inst_valid = (count != '0);
  assign deq        = inst_valid && deq_ready;
  // A full queue can still fetch when the head leaves in the same cycle.
  assign enq        = rst && !branch_taken && !halt_q && ((count < FULL) || deq);

  assign imem_rd   = enq;
  assign imem_addr = fetch_pc;
  assign inst      = inst_valid ? word_mem[rd_ptr] : 32'h0;
  assign inst_pc   = inst_valid ? pc_mem[rd_ptr]   : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (branch_taken) begin
      fetch_pc <= branch_target;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + PC_INC;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq && !deq) begin
        count <= count + 1'b1;
      end else if (!enq && deq) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage is not reset; occupancy masks stale entries from the outputs.
  always_ff @(posedge clk) begin
    if (enq) begin
      word_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_q <= 1'b0;
    end else if (branch_taken) begin
      halt_q <= 1'b0;
    end else if (enq && (imem_data == 32'hFFFF_FFFF)) begin
      halt_q <= 1'b1;
    end
  end

  assign halted = halt_q;
`else
  assign halt_q = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: hand-derived per-cycle vector table plus a queue scoreboard of fetched {pc, word}.
module tb_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        deq_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  count;
`ifdef FETCH_HALT_EN
  logic        halted;
`endif
  logic        halt_word;

  always #5 clk = ~clk;

  // Memory: each word equals its address, except an optional halt word at 8.
  assign imem_data = (halt_word && imem_addr == 32'h8) ? 32'hFFFF_FFFF : imem_addr;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .branch_taken(branch_taken), .branch_target(branch_target), .deq_ready(deq_ready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .count(count)
`ifdef FETCH_HALT_EN
    , .halted(halted)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  typedef struct {
    logic        r, dr, bt;
    logic [31:0] tgt;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    logic [31:0] e_addr;
    logic        e_rd;
  } vec_t;

  ent_t        sbq[$];
  vec_t        tbl[$];
  logic [31:0] m_pc;
  bit          m_halt;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (halt_word && a == 32'h8) ? 32'hFFFF_FFFF : a;
  endfunction

  function automatic bit m_rd();
    return rst && !branch_taken && !m_halt &&
           ((sbq.size() < DEPTH) || (sbq.size() != 0 && deq_ready));
  endfunction

  task automatic model_reset();
    sbq.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
  endtask

  task automatic model_update();
    bit   rd;
    bit   dq;
    ent_t e;
    if (!rst) begin
      model_reset();
    end else begin
      rd = m_rd();
      dq = (sbq.size() != 0) && deq_ready;
      if (branch_taken) begin
        sbq.delete();
        m_pc   = branch_target;
        m_halt = 1'b0;
      end else begin
        if (dq) void'(sbq.pop_front());
        if (rd) begin
          e.pc   = m_pc;
          e.word = mem_fn(m_pc);
          sbq.push_back(e);
          if (HALT_EN && e.word == 32'hFFFF_FFFF) m_halt = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic sb_check();
    chk("sb imem_addr", imem_addr, m_pc);
    chk("sb imem_rd", 32'(imem_rd), 32'(m_rd()));
    chk("sb count", 32'(count), 32'(sbq.size()));
    chk("sb inst_valid", 32'(inst_valid), 32'(sbq.size() != 0));
    if (sbq.size() != 0) begin
      chk("sb inst_pc", inst_pc, sbq[0].pc);
      chk("sb inst", inst, sbq[0].word);
    end else begin
      chk("sb inst_pc empty", inst_pc, 32'h0);
      chk("sb inst empty", inst, 32'h0);
    end
`ifdef FETCH_HALT_EN
    chk("sb halted", 32'(halted), 32'(m_halt));
`endif
  endtask

  task automatic drive(input logic r, input logic dr, input logic bt, input logic [31:0] tgt);
    rst           = r;
    deq_ready     = dr;
    branch_taken  = bt;
    branch_target = tgt;
    if (!r) model_reset();
  endtask

  task automatic sample();
    @(negedge clk);
    sb_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic add(input logic r, input logic dr, input logic bt, input logic [31:0] tgt,
                     input logic v, input logic [31:0] pc, input logic [31:0] cnt,
                     input logic [31:0] addr, input logic rd);
    vec_t x;
    x.r = r; x.dr = dr; x.bt = bt; x.tgt = tgt;
    x.e_v = v; x.e_pc = pc; x.e_cnt = cnt; x.e_addr = addr; x.e_rd = rd;
    tbl.push_back(x);
  endtask

  // Asynchronous reset mid-cycle with entries queued: outputs clear without a clock edge.
  task automatic hand_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async rst inst_valid", 32'(inst_valid), 32'h0);
    chk("async rst inst", inst, 32'h0);
    chk("async rst inst_pc", inst_pc, 32'h0);
    chk("async rst count", 32'(count), 32'h0);
    chk("async rst imem_rd", 32'(imem_rd), 32'h0);
    chk("async rst imem_addr", imem_addr, 32'h0);
    advance();
  endtask

  initial begin
    int mark;
    halt_word = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("reset inst_valid", 32'(inst_valid), 32'h0);
    chk("reset count", 32'(count), 32'h0);
    chk("reset imem_rd", 32'(imem_rd), 32'h0);
    chk("reset imem_addr", imem_addr, 32'h0);
    advance();

    //  r  dr bt tgt            v  pc             cnt addr           rd
    add(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,          1);
    add(1, 1, 0, 32'h0,         1, 32'h0,         1, 32'h4,          1);
    add(1, 1, 0, 32'h0,         1, 32'h4,         1, 32'h8,          1);
    add(1, 1, 0, 32'h0,         1, 32'h8,         1, 32'hC,          1);
    add(1, 1, 0, 32'h0,         1, 32'hC,         1, 32'h10,         1);
    add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,          0);
    add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,          1);
    add(1, 0, 0, 32'h0,         1, 32'h0,         1, 32'h4,          1);
    add(1, 0, 0, 32'h0,         1, 32'h0,         2, 32'h8,          1);
    add(1, 0, 0, 32'h0,         1, 32'h0,         3, 32'hC,          1);
    add(1, 0, 0, 32'h0,         1, 32'h0,         4, 32'h10,         0);
    add(1, 0, 0, 32'h0,         1, 32'h0,         4, 32'h10,         0);
    add(1, 1, 0, 32'h0,         1, 32'h0,         4, 32'h10,         1);
    add(1, 1, 0, 32'h0,         1, 32'h4,         4, 32'h14,         1);
    add(1, 1, 0, 32'h0,         1, 32'h8,         4, 32'h18,         1);
    add(1, 1, 0, 32'h0,         1, 32'hC,         4, 32'h1C,         1);
    add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,          0);
    add(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,          1);
    add(1, 1, 0, 32'h0,         1, 32'h0,         1, 32'h4,          1);
    add(1, 1, 0, 32'h0,         1, 32'h4,         1, 32'h8,          1);
    add(1, 0, 0, 32'h0,         1, 32'h8,         1, 32'hC,          1);
    add(1, 0, 1, 32'h100,       1, 32'h8,         2, 32'h10,         0);
    add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h100,        1);
    add(1, 0, 0, 32'h0,         1, 32'h100,       1, 32'h104,        1);
    add(1, 0, 0, 32'h0,         1, 32'h100,       2, 32'h108,        1);
    add(1, 0, 0, 32'h0,         1, 32'h100,       3, 32'h10C,        1);
    add(1, 1, 1, 32'h200,       1, 32'h100,       4, 32'h110,        0);
    add(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h200,        1);
    add(1, 1, 0, 32'h0,         1, 32'h200,       1, 32'h204,        1);
    add(1, 0, 0, 32'h0,         1, 32'h204,       1, 32'h208,        1);
    add(1, 0, 0, 32'h0,         1, 32'h204,       2, 32'h20C,        1);
    add(1, 0, 0, 32'h0,         1, 32'h204,       3, 32'h210,        1);
    mark = tbl.size() - 1;
    add(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,          1);
    add(1, 1, 0, 32'h0,         1, 32'h0,         1, 32'h4,          1);
    add(1, 1, 1, 32'hFFFF_FFFC, 1, 32'h4,         1, 32'h8,          0);
    add(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFFC,  1);
    add(1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h0,          1);
    add(1, 1, 0, 32'h0,         1, 32'h0,         1, 32'h4,          1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].dr, tbl[i].bt, tbl[i].tgt);
      sample();
      chk($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_v));
      chk($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].e_pc);
      chk($sformatf("row%0d count", i), 32'(count), tbl[i].e_cnt);
      chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d imem_rd", i), 32'(imem_rd), 32'(tbl[i].e_rd));
      if (i == mark) hand_reset();
      else advance();
    end

`ifdef FETCH_HALT_EN
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    halt_word = 1'b1;
    sample();
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      sample();
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    chk("halt halted set", 32'(halted), 32'h1);
    chk("halt imem_rd", 32'(imem_rd), 32'h0);
    chk("halt imem_addr", imem_addr, 32'hC);
    chk("halt count", 32'(count), 32'h3);
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      sample();
      chk($sformatf("halt drain%0d pc", k), inst_pc, 32'(k * 4));
      if (k == 2) chk("halt drain word", inst, 32'hFFFF_FFFF);
      advance();
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    sample();
    chk("halt drained count", 32'(count), 32'h0);
    chk("halt still halted", 32'(halted), 32'h1);
    chk("halt drained imem_rd", 32'(imem_rd), 32'h0);
    advance();
    drive(1'b1, 1'b0, 1'b1, 32'h40);
    sample();
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    chk("halt cleared", 32'(halted), 32'h0);
    chk("halt resume addr", imem_addr, 32'h40);
    chk("halt resume imem_rd", 32'(imem_rd), 32'h1);
    advance();
    halt_word = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end for the CPU core; sits directly upstream of decode / REGFILE read.
- Holds the fetch PC and issues reads to the instruction MEMORY, which returns data combinationally in the same cycle.
- Buffers fetched words and their PCs in a small FIFO so decode can stall without losing fetches.
- Flushes and redirects on a taken branch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0, fetch PC loaded on reset.
- PC_INC, 4, amount added to the fetch PC after each accepted fetch.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst = 0 resets).
- imem_addr  out  32  instruction memory address; equals the current fetch PC.
- imem_rd  out  1  fetch request this cycle.
- imem_data  in  32  instruction word at imem_addr; valid in the same cycle.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  32  new fetch PC when branch_taken = 1.
- deq_ready  in  1  decode accepts the head entry this cycle.
- inst_valid  out  1  head entry present.
- inst  out  32  head instruction word.
- inst_pc  out  32  PC of the head instruction.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc = RESET_PC; read and write pointers = 0; count = 0.
  - inst_valid = 0; inst = 0; inst_pc = 0; imem_rd = 0.
  - Reset applies immediately, mid-operation included; all queued entries are discarded.
- Outputs:
  - imem_addr = fetch_pc at all times (combinational).
  - inst and inst_pc come combinationally from the head entry; both are 0 when empty.
  - inst_valid = (count != 0).
- Enqueue condition (enq): imem_rd = !branch_taken && (count < DEPTH || deq).
  - On enq, {imem_data, fetch_pc} is written at the write pointer, and fetch_pc <= fetch_pc + PC_INC.
- Dequeue condition (deq): deq = inst_valid && deq_ready; the read pointer advances.
- Count: count <= count + enq - deq.
  - Full with simultaneous deq still enqueues, so count stays at DEPTH.
  - Empty: deq_ready is ignored.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Branch (branch_taken = 1), highest priority:
  - Next edge: both pointers = 0, count = 0, fetch_pc <= branch_target.
  - No enqueue in the branch cycle; imem_rd = 0.
  - A deq in the same cycle is treated as consumed by decode, but the queue is cleared regardless.
  - First post-branch fetch happens in the following cycle; inst_valid first returns 1 the cycle after that.
- Latency: an empty queue fetching at PC X gives inst_valid = 1 with inst_pc = X one cycle later. There is no combinational bypass from imem_data to inst.
- Arithmetic: PC addition is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Throughput: one instruction per cycle sustained when deq_ready is held at 1.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - An internal halted flag sets on the edge that enqueues imem_data == 32'hFFFF_FFFF. That word is still enqueued.
  - While halted, imem_rd = 0 and fetch_pc holds. Queued entries still drain normally.
  - halted clears on branch_taken (normal redirect) or reset.
  - Adds output port halted, 1 bit, reset 0.
- Undefined: no halted port and no halt logic; 32'hFFFF_FFFF is fetched like any other word.

Test Plan:
- Reset then deq_ready = 1, memory word at each address = its address:
  - Cycle 1 after rst rises: inst_valid = 1, inst_pc = 0.
  - Then inst_pc = 4, 8, 12 on consecutive cycles; count stays 1.
- deq_ready = 0 from reset, DEPTH = 4:
  - count reaches 4 after 4 cycles; imem_rd = 0 and imem_addr = 16 thereafter.
  - Raise deq_ready: entries pop with PCs 0, 4, 8, 12; fetch resumes at 16 in the same cycle as the first pop.
- Queue holding PCs 8 and 12, branch_taken = 1 with branch_target = 32'h100:
  - Next cycle: count = 0 and imem_addr = 32'h100.
  - The cycle after that: inst_pc = 32'h100.
- Full queue, deq_ready = 1, and branch_taken asserted in the same cycle: branch wins, queue empty next cycle, fetch_pc = target.
- Assert rst low mid-stream with count = 3: outputs are immediately 0 and count = 0; after release, fetch restarts at RESET_PC.
- With FETCH_HALT_EN, word 32'hFFFF_FFFF at address 8:
  - halted = 1 after that word is enqueued; imem_rd stays 0.
  - Entries 0, 4, 8 drain.
  - branch_taken to 32'h40 clears halted; fetch resumes at 32'h40.
